search_sequencer: RTL
=====================

# search_sequencer

Top-level controller for the greedy line-search engine (`Add_Remove_Search`) in the string-art pipeline. On a host `start`, it repeatedly issues search requests to the engine and accepts each returned move (pin pair plus add/remove flag). It writes every accepted move into an external move-log RAM and keeps running add/remove bookkeeping. It stops on engine `done`, a move-count limit, host abort, or an illegal remove, and reports the cause.

## Interface
Parameters:
- `PIN_W`, 8: pin index width.
- `LOG_AW`, 12: move-log address width.
- `MAX_MOVES`, 4096: move limit; legal range 1..2^LOG_AW.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle run request; honoured only in IDLE.
- `abort`  in  1  level; ends the run early.
- `busy`  out  1  high in every state except IDLE.
- `finished`  out  1  one-cycle pulse when a run ends.
- `stop_cause`  out  2  0 ENGINE_DONE, 1 LIMIT, 2 ABORT, 3 UNDERFLOW; held until the next `start`.
- `move_count`  out  LOG_AW+1  number of moves logged in the current run.
- `active_lines`  out  LOG_AW+1  adds minus removes.
- `srch_req_val`  out  1  search request valid.
- `srch_req_rdy`  in  1  engine accepts request.
- `srch_resp_val`  in  1  engine response valid.
- `srch_resp_rdy`  out  1  sequencer accepts response.
- `srch_pin_1`, `srch_pin_2`  in  PIN_W  move endpoints.
- `srch_add_or_remove`  in  1  1 = add line, 0 = remove line.
- `srch_done`  in  1  engine has no improving move; qualified by `srch_resp_val`.
- `log_we`  out  1  move-log write strobe.
- `log_addr`  out  LOG_AW  write address.
- `log_data`  out  2*PIN_W+1  {add_or_remove, pin_1, pin_2}.

## Operation
States and transitions:
- IDLE: on `start`, clear `move_count` and `active_lines`, clear `stop_cause` to 0, then go to REQ.
- REQ: `srch_req_val = !abort` (combinational).
  - `abort` high: go to FINISH with cause ABORT; no transfer occurs.
  - Otherwise `srch_req_val & srch_req_rdy`: go to WAIT.
- WAIT: `srch_resp_rdy = 1`.
  - An `abort` seen in WAIT sets a sticky `abort_pend` flag.
  - On `srch_resp_val`, priority order:
    - `abort_pend` or `abort`: discard the response, FINISH with ABORT.
    - `srch_done`: FINISH with ENGINE_DONE; pins are ignored and nothing is logged.
    - Remove with `active_lines == 0`: FINISH with UNDERFLOW; nothing is logged.
    - Otherwise register the pins and flag, then go to LOG.
- LOG: drive `log_we = 1` for exactly one cycle, with `log_addr = move_count[LOG_AW-1:0]`.
  - Increment `move_count`; adjust `active_lines` by ±1.
  - Next state, priority order:
    - If the new `move_count == MAX_MOVES`: FINISH with LIMIT.
    - Else if `abort`: FINISH with ABORT.
    - Else: REQ.
- FINISH: `finished = 1` for one cycle, then IDLE. Counters and `stop_cause` hold their values.

Other rules:
- `start` is ignored outside IDLE.
- `abort` has no effect in IDLE or FINISH.
- Only one request is ever outstanding.
- Counter arithmetic is unsigned, LOG_AW+1 bits. Neither counter can wrap: the LIMIT and UNDERFLOW checks prevent it.

## Timing
- Reset (async assert): state IDLE; `busy`, `finished`, `stop_cause`, `move_count`, `active_lines`, `log_we`, `log_addr`, `log_data`, `srch_req_val`, `srch_resp_rdy` and `abort_pend` are all 0.
- Reset mid-run drops the outstanding engine transaction. The engine is reset on the same `reset` net.
- All outputs are registered or decoded from state, except `srch_req_val`, which is gated by `abort`.
- `start` sampled at edge N: `busy` and `srch_req_val` are high from cycle N+1.
- Move throughput with zero-wait engine: REQ → WAIT → LOG is 3 cycles per logged move.
- `finished` is asserted the cycle after the terminating event. `stop_cause` and the counters are valid in that same cycle.
- Response arriving in the same cycle as `srch_req_val & srch_req_rdy` is not accepted; `srch_resp_rdy` is low in REQ.

## Test plan
- Engine returns 3 adds, then done -> 3 log writes at addresses 0, 1, 2; `move_count = 3`, `active_lines = 3`; `finished` pulse; `stop_cause = 0`.
- MAX_MOVES = 4, engine never done -> exactly 4 writes; `stop_cause = 1`; `srch_req_val` never re-asserts after the 4th LOG.
- Add (5,17), then remove (5,17), then remove -> 2 writes, `active_lines = 0`, `stop_cause = 3`; the third move is not written.
- `abort` pulsed during WAIT, response arrives 4 cycles later -> response consumed but not logged; `stop_cause = 2`; `move_count` unchanged.
- `abort` high in REQ with `srch_req_rdy = 1` -> no request transfer; FINISH next cycle; `stop_cause = 2`.
- `reset` asserted in LOG, and `start` pulsed while busy -> all outputs 0 immediately on reset; the busy-time `start` causes no restart or counter clear.

Source files
------------

// File: rtl/search_sequencer_if.sv
// Engine handshake plus move-log write port of the search sequencer.
// No timing of its own: a bundle of wires between sequencer, engine and log RAM.
// Engine flow control is valid/ready in both directions; the log port is write-only.
interface search_sequencer_if #(
  parameter int PIN_W  = 8,
  parameter int LOG_AW = 12
) ();
  logic               srch_req_val;
  logic               srch_req_rdy;
  logic               srch_resp_val;
  logic               srch_resp_rdy;
  logic [PIN_W-1:0]   srch_pin_1;
  logic [PIN_W-1:0]   srch_pin_2;
  logic               srch_add_or_remove;
  logic               srch_done;
  logic               log_we;
  logic [LOG_AW-1:0]  log_addr;
  logic [2*PIN_W:0]   log_data;

  // Sequencer side
  modport master (
    output srch_req_val,
    input  srch_req_rdy,
    input  srch_resp_val,
    output srch_resp_rdy,
    input  srch_pin_1,
    input  srch_pin_2,
    input  srch_add_or_remove,
    input  srch_done,
    output log_we,
    output log_addr,
    output log_data
  );

  // Engine / log RAM side
  modport slave (
    input  srch_req_val,
    output srch_req_rdy,
    output srch_resp_val,
    input  srch_resp_rdy,
    output srch_pin_1,
    output srch_pin_2,
    output srch_add_or_remove,
    output srch_done,
    input  log_we,
    input  log_addr,
    input  log_data
  );
endinterface

// File: rtl/search_sequencer.sv
// Drives the greedy line-search engine: request, accept move, log it, count it, until a stop cause.
// Latency: busy one cycle after start; 3 cycles per logged move (REQ, WAIT, LOG) with a zero-wait engine.
// Backpressure: one outstanding request; request held until srch_req_rdy, response taken only in WAIT.
module search_sequencer #(
  parameter int PIN_W     = 8,
  parameter int LOG_AW    = 12,
  parameter int MAX_MOVES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 finished,
  output logic [1:0]           stop_cause,
  output logic [LOG_AW:0]      move_count,
  output logic [LOG_AW:0]      active_lines,
  search_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LOG,
    S_FINISH
  } state_t;

  localparam logic [1:0] CAUSE_DONE  = 2'd0;
  localparam logic [1:0] CAUSE_LIMIT = 2'd1;
  localparam logic [1:0] CAUSE_ABORT = 2'd2;
  localparam logic [1:0] CAUSE_UNDER = 2'd3;

  localparam logic [LOG_AW:0] MAX_CNT = (LOG_AW+1)'(MAX_MOVES);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        cause_nxt;
  logic              capture;
  logic              abort_pend;
  logic [2*PIN_W:0]  move_q;
  logic [LOG_AW:0]   count_inc;

  assign count_inc = move_count + 1'b1;

  // Next-state and stop-cause selection
  always_comb begin
    state_nxt = state;
    cause_nxt = stop_cause;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (abort) begin
          state_nxt = S_FINISH;
          cause_nxt = CAUSE_ABORT;
        end else if (bus.srch_req_rdy) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.srch_resp_val) begin
          state_nxt = S_FINISH;
          if (abort_pend || abort) begin
            cause_nxt = CAUSE_ABORT;
          end else if (bus.srch_done) begin
            cause_nxt = CAUSE_DONE;
          end else if (!bus.srch_add_or_remove && active_lines == '0) begin
            cause_nxt = CAUSE_UNDER;
          end else begin
            capture   = 1'b1;
            state_nxt = S_LOG;
          end
        end
      end
      S_LOG: begin
        if (count_inc == MAX_CNT) begin
          state_nxt = S_FINISH;
          cause_nxt = CAUSE_LIMIT;
        end else if (abort) begin
          state_nxt = S_FINISH;
          cause_nxt = CAUSE_ABORT;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Stop cause: cleared by an accepted start, otherwise loaded on the way into FINISH
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        stop_cause <= CAUSE_DONE;
    else if (state == S_IDLE && start) stop_cause <= CAUSE_DONE;
    else                              stop_cause <= cause_nxt;
  end

  // Move and line counters: cleared on start, stepped once per logged move
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_count   <= '0;
      active_lines <= '0;
    end else if (state == S_IDLE && start) begin
      move_count   <= '0;
      active_lines <= '0;
    end else if (state == S_LOG) begin
      move_count   <= count_inc;
      active_lines <= move_q[2*PIN_W] ? active_lines + 1'b1 : active_lines - 1'b1;
    end
  end

  // Abort seen while waiting is remembered until the response arrives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) abort_pend <= 1'b0;
    else       abort_pend <= (state == S_WAIT) && !bus.srch_resp_val && (abort_pend || abort);
  end

  // Capture the accepted move for the log write
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        move_q <= '0;
    else if (capture) move_q <= {bus.srch_add_or_remove, bus.srch_pin_1, bus.srch_pin_2};
  end

  assign busy              = (state != S_IDLE);
  assign finished          = (state == S_FINISH);
  assign bus.srch_req_val  = (state == S_REQ) && !abort;
  assign bus.srch_resp_rdy = (state == S_WAIT);
  assign bus.log_we        = (state == S_LOG);
  assign bus.log_addr      = move_count[LOG_AW-1:0];
  assign bus.log_data      = move_q;

endmodule
